// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised oversampled UART receiver with parity, stop-bit config and break detect
module uart_rx_cfg #(
    parameter int DBITS = 8,
    parameter int OS    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             rx,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic [DBITS-1:0] rx_dout,
    output logic             rx_done,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det
);

    localparam int CW = $clog2(OS);
    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [CW-1:0] C_S0   = CW'(OS / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OS / 2);
    localparam logic [CW-1:0] C_VOTE = CW'(OS / 2 + 1);
    localparam logic [CW-1:0] C_END  = CW'(OS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic [2:0]       r_state;
    logic             r_sync1, r_sync2;
    logic [CW-1:0]    r_c;
    logic [NW-1:0]    r_n;
    logic             r_s0, r_s1;
    logic [DBITS-1:0] r_shift;
    logic             r_par_en, r_par_odd, r_two_stop;
    logic             r_stop_idx, r_stop0, r_par_bit;
    logic             r_perr_f, r_ferr_f;
    logic [DBITS-1:0] r_dout;
    logic             r_done, r_perr, r_ferr, r_brk;

    logic w_rxs, w_vote, w_vote_tick, w_end_tick, w_par_exp, w_last_stop, w_first_stop_val, w_counting;

    assign w_rxs            = r_sync2;
    assign w_vote           = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_vote_tick      = s_tick && (r_c == C_VOTE);
    assign w_end_tick       = s_tick && (r_c == C_END);
    assign w_par_exp        = (^r_shift) ^ r_par_odd;
    assign w_last_stop      = !r_two_stop || r_stop_idx;
    assign w_first_stop_val = r_stop_idx ? r_stop0 : w_vote;
    assign w_counting       = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_c        <= '0;
            r_n        <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop_idx <= 1'b0;
            r_stop0    <= 1'b0;
            r_par_bit  <= 1'b0;
            r_perr_f   <= 1'b0;
            r_ferr_f   <= 1'b0;
            r_dout     <= '0;
            r_done     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;

            if (w_counting && s_tick) begin
                if (r_c == C_S0) r_s0 <= w_rxs;
                if (r_c == C_S1) r_s1 <= w_rxs;
                r_c <= (r_c == C_END) ? '0 : r_c + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    // A tick coinciding with start detection is dropped because c is forced to 0 here.
                    if (!w_rxs) begin
                        r_state    <= S_START;
                        r_c        <= '0;
                        r_par_en   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                        r_par_odd  <= (parity_mode == 2'd2);
                        r_two_stop <= two_stop;
                        r_stop_idx <= 1'b0;
                        r_par_bit  <= 1'b0;
                        r_perr_f   <= 1'b0;
                        r_ferr_f   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_vote_tick && w_vote) begin
                        r_state <= S_IDLE;
                    end else if (w_end_tick) begin
                        r_state <= S_DATA;
                        r_n     <= '0;
                    end
                end
                S_DATA: begin
                    if (w_vote_tick) r_shift <= {w_vote, r_shift[DBITS-1:1]};
                    if (w_end_tick) begin
                        if (r_n == N_LAST) r_state <= r_par_en ? S_PARITY : S_STOP;
                        else               r_n     <= r_n + NW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_vote_tick) begin
                        r_perr_f  <= (w_vote != w_par_exp);
                        r_par_bit <= w_vote;
                    end
                    if (w_end_tick) r_state <= S_STOP;
                end
                S_STOP: begin
                    // Completing at the vote of the last stop bit leaves half a bit of slack for the next start edge.
                    if (w_vote_tick) begin
                        if (!r_stop_idx) r_stop0 <= w_vote;
                        if (w_last_stop) begin
                            r_done  <= 1'b1;
                            r_dout  <= r_shift;
                            r_perr  <= r_perr_f;
                            r_ferr  <= r_ferr_f | !w_vote;
                            r_brk   <= (r_shift == '0) && !(r_par_en && r_par_bit) && !w_first_stop_val;
                            r_state <= w_vote ? S_IDLE : S_WAIT_HIGH;
                        end else if (!w_vote) begin
                            r_ferr_f <= 1'b1;
                        end
                    end
                    if (w_end_tick) r_stop_idx <= 1'b1;
                end
                S_WAIT_HIGH: begin
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_dout    = r_dout;
    assign rx_done    = r_done;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign break_det  = r_brk;

endmodule
